rv32_trap_csr_unit: RTL and testbench
=====================================

# rv32_trap_csr_unit

Machine-mode CSR file and trap controller for the RV32I core. It consumes the exception causes, CSR addresses and MRET/WFI encodings the decoder produces, updates mstatus/mepc/mcause/mtval, and drives the PC redirect into fetch. It sits beside the execute stage as the receiving end of the pipeline's exception/CSR signalling.

## Interface
- MTVEC_RESET, 32'h0000_0000, reset trap vector (bits[1:0] forced 0)
- MISA_VALUE, 32'h4000_0100, read-only misa (RV32I)
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- csr_req_i  in  1  CSR instruction valid this cycle
- csr_op_i  in  2  01 RW, 10 RS, 11 RC (00 = read only)
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  32  rs1/zimm operand
- csr_rdata_o  out  32  old CSR value (combinational)
- csr_illegal_o  out  1  unknown address with csr_req_i (combinational)
- exc_valid_i  in  1  synchronous exception
- exc_cause_i  in  5  cause code (0, 2, 11)
- exc_pc_i  in  32  faulting PC
- exc_tval_i  in  32  mtval value
- mret_i, wfi_i  in  1 each  decoded MRET / WFI
- irq_ext_i  in  1  machine external interrupt, level
- irq_pc_i  in  32  PC to resume after interrupt
- instr_retire_i  in  1  one instruction retired
- redirect_o  out  1  one-cycle fetch redirect pulse
- redirect_pc_o  out  32  redirect target
- stall_o  out  1  pipeline hold (WFI)

## Operation
- CSRs: mstatus (MIE bit3, MPIE bit7 writable; MPP reads 2'b11), misa (writes ignored), mie (only bit11 MEIE writable), mtvec/mepc (bits[1:0] read 0), mcause, mtval.
- Reset: all CSRs 0 except mtvec=MTVEC_RESET; mstatus reads 32'h0000_1800. redirect_o=0, redirect_pc_o=0, stall_o=0, FSM=RUN.
- Per-cycle priority in RUN: exc_valid_i > mret_i > interrupt > wfi_i > csr_req_i. Lower-priority events in the same cycle are dropped (no CSR write).
- Exception: mepc=exc_pc_i, mcause={27'b0,cause}, mtval=exc_tval_i, MPIE=MIE, MIE=0; target {mtvec[31:2],2'b00}.
- Interrupt: taken if irq_ext_i && MEIE && MIE; mepc=irq_pc_i, mcause=32'h8000_000B, mtval=0, MPIE=MIE, MIE=0; target mtvec.
- MRET: MIE=MPIE, MPIE=1; target mepc.
- CSR write value: RW=wdata, RS=old|wdata, RC=old&~wdata; op 00 never writes. Illegal address: no write.
- FSM: RUN -> REDIRECT on trap/MRET; REDIRECT -> RUN unconditionally (all inputs ignored during REDIRECT). RUN -> SLEEP on wfi_i. SLEEP: stall_o=1; on irq_ext_i && MEIE -> if MIE take interrupt (-> REDIRECT), else -> RUN.
- rst mid-operation: immediate return to reset state, from any FSM state.

## Timing
- Trap/MRET sampled at edge N; redirect_o=1 with redirect_pc_o valid for exactly cycle N+1, then 0. redirect_pc_o holds its last value.
- CSR write at edge N; a read in cycle N+1 sees the new value.
- stall_o high from the cycle after the wfi_i edge until the wake edge, inclusive of no extra cycle.

## Configuration
- RISCV_ZICNTR_EN defined: 64-bit mcycle (0xB00/0xB80) and minstret (0xB02/0xB82), read/write. mcycle increments every cycle, including SLEEP. minstret increments on instr_retire_i. On a write coinciding with an increment, the write wins.
- Not defined: these addresses are illegal, and instr_retire_i is ignored.

## Structure
- Shared package: CSR addresses (existing plus MCYCLE/MINSTRET/H), mstatus bit indices, interrupt cause code 11, csr_op enum, FSM state enum {RUN, REDIRECT, SLEEP}.
- Sub-module: rv32_csr_counter64 (64-bit counter with split-half write and increment enable), instantiated twice under the macro.

## Test plan
- Reset, then read 0x300 / 0x301 / 0x305 -> 32'h1800 / 32'h4000_0100 / MTVEC_RESET, with all outputs 0.
- Write mtvec=0x100 (RW), then exc_valid_i cause 2, pc 0x40, tval 0xDEAD -> next cycle redirect_o=1 to 0x100; mepc=0x40, mcause=2, mtval=0xDEAD, MIE=0.
- Set MIE and MEIE, then MRET after a trap -> redirect to mepc; MIE restored to 1, MPIE=1.
- wfi_i with MEIE=1, MIE=1 -> stall_o held; raise irq_ext_i -> mcause=0x8000_000B, mepc=irq_pc_i, redirect to mtvec.
- exc_valid_i and csr_req_i RW mie in the same cycle -> mie unchanged, exception taken. Read of 0x7FF -> csr_illegal_o=1.
- With RISCV_ZICNTR_EN: write mcycle=0xFFFF_FFFF -> after 1 cycle mcycleh=1. Without it, 0xB00 is illegal.

Source files
------------

// File: rtl/rv32_trap_csr_pkg.sv
// ============================================================================
// Module      : rv32_trap_csr_pkg
// Description : Shared CSR addresses, mstatus/mie bit positions, CSR op and
//               trap-unit state encodings for the RV32I machine-mode CSR file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_trap_csr_pkg;

    localparam logic [11:0] c_addr_mstatus   = 12'h300;
    localparam logic [11:0] c_addr_misa      = 12'h301;
    localparam logic [11:0] c_addr_mie       = 12'h304;
    localparam logic [11:0] c_addr_mtvec     = 12'h305;
    localparam logic [11:0] c_addr_mepc      = 12'h341;
    localparam logic [11:0] c_addr_mcause    = 12'h342;
    localparam logic [11:0] c_addr_mtval     = 12'h343;
    localparam logic [11:0] c_addr_mcycle    = 12'hB00;
    localparam logic [11:0] c_addr_minstret  = 12'hB02;
    localparam logic [11:0] c_addr_mcycleh   = 12'hB80;
    localparam logic [11:0] c_addr_minstreth = 12'hB82;

    localparam int c_mstatus_mie  = 3;
    localparam int c_mstatus_mpie = 7;
    localparam int c_mie_meie     = 11;

    localparam logic [4:0] c_cause_mei = 5'd11;

    typedef enum logic [1:0] {
        CSR_OP_READ = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        SLEEP    = 2'd2
    } state_e;

    function automatic logic [31:0] csr_apply(input csr_op_e op,
                                              input logic [31:0] old_val,
                                              input logic [31:0] wdata);
        case (op)
            CSR_OP_RW: return wdata;
            CSR_OP_RS: return old_val | wdata;
            CSR_OP_RC: return old_val & ~wdata;
            default:   return old_val;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32_csr_counter64.sv
// ============================================================================
// Module      : rv32_csr_counter64
// Description : 64-bit CSR counter with independent 32-bit half writes and an
//               increment enable; a write in a cycle suppresses the increment.
//               Used only when RISCV_ZICNTR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (wr_lo_i) begin
            r_count[31:0] <= wdata_i;
        end else if (wr_hi_i) begin
            r_count[63:32] <= wdata_i;
        end else if (inc_i) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/rv32_trap_csr_unit.sv
// ============================================================================
// Module      : rv32_trap_csr_unit
// Description : Machine-mode CSR file and trap controller (exceptions, MRET,
//               external interrupt, WFI sleep) driving the fetch redirect.
//               Define RISCV_ZICNTR_EN to add mcycle/minstret counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_trap_csr_unit
    import rv32_trap_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_req_i,
    input  logic [1:0]  csr_op_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_illegal_o,
    input  logic        exc_valid_i,
    input  logic [4:0]  exc_cause_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] exc_tval_i,
    input  logic        mret_i,
    input  logic        wfi_i,
    input  logic        irq_ext_i,
    input  logic [31:0] irq_pc_i,
    input  logic        instr_retire_i,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        stall_o
);

    state_e      r_state, w_state_nxt;
    logic        r_mie, r_mpie, r_meie;
    logic [31:2] r_mtvec, r_mepc;
    logic [31:0] r_mcause, r_mtval, r_redirect_pc;
    logic        w_take_exc, w_take_irq, w_take_mret, w_csr_we, w_addr_ok;
    logic [31:0] w_rdata, w_wval;
    logic        w_unused;

`ifdef RISCV_ZICNTR_EN
    logic [63:0] w_mcycle, w_minstret;

    rv32_csr_counter64 u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (1'b1),
        .wr_lo_i (w_csr_we && csr_addr_i == c_addr_mcycle),
        .wr_hi_i (w_csr_we && csr_addr_i == c_addr_mcycleh),
        .wdata_i (w_wval),
        .count_o (w_mcycle)
    );

    rv32_csr_counter64 u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (instr_retire_i),
        .wr_lo_i (w_csr_we && csr_addr_i == c_addr_minstret),
        .wr_hi_i (w_csr_we && csr_addr_i == c_addr_minstreth),
        .wdata_i (w_wval),
        .count_o (w_minstret)
    );

    assign w_unused = ^{exc_pc_i[1:0], irq_pc_i[1:0]};
`else
    assign w_unused = ^{exc_pc_i[1:0], irq_pc_i[1:0], instr_retire_i};
`endif

    always_comb begin
        w_rdata   = '0;
        w_addr_ok = 1'b1;
        case (csr_addr_i)
            c_addr_mstatus: begin
                w_rdata[12:11]          = 2'b11;
                w_rdata[c_mstatus_mpie] = r_mpie;
                w_rdata[c_mstatus_mie]  = r_mie;
            end
            c_addr_misa:      w_rdata = MISA_VALUE;
            c_addr_mie:       w_rdata[c_mie_meie] = r_meie;
            c_addr_mtvec:     w_rdata = {r_mtvec, 2'b00};
            c_addr_mepc:      w_rdata = {r_mepc, 2'b00};
            c_addr_mcause:    w_rdata = r_mcause;
            c_addr_mtval:     w_rdata = r_mtval;
`ifdef RISCV_ZICNTR_EN
            c_addr_mcycle:    w_rdata = w_mcycle[31:0];
            c_addr_mcycleh:   w_rdata = w_mcycle[63:32];
            c_addr_minstret:  w_rdata = w_minstret[31:0];
            c_addr_minstreth: w_rdata = w_minstret[63:32];
`endif
            default:          w_addr_ok = 1'b0;
        endcase
    end

    assign csr_rdata_o   = w_rdata;
    assign csr_illegal_o = csr_req_i && !w_addr_ok;
    assign w_wval        = csr_apply(csr_op_e'(csr_op_i), w_rdata, csr_wdata_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Only one event is accepted per cycle; everything below it is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_take_exc  = 1'b0;
        w_take_irq  = 1'b0;
        w_take_mret = 1'b0;
        w_csr_we    = 1'b0;
        case (r_state)
            RUN: begin
                if (exc_valid_i) begin
                    w_take_exc  = 1'b1;
                    w_state_nxt = REDIRECT;
                end else if (mret_i) begin
                    w_take_mret = 1'b1;
                    w_state_nxt = REDIRECT;
                end else if (irq_ext_i && r_meie && r_mie) begin
                    w_take_irq  = 1'b1;
                    w_state_nxt = REDIRECT;
                end else if (wfi_i) begin
                    w_state_nxt = SLEEP;
                end else if (csr_req_i && csr_op_i != CSR_OP_READ && w_addr_ok) begin
                    w_csr_we = 1'b1;
                end
            end
            REDIRECT: w_state_nxt = RUN;
            SLEEP: begin
                if (irq_ext_i && r_meie) begin
                    w_take_irq  = r_mie;
                    w_state_nxt = r_mie ? REDIRECT : RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mie         <= 1'b0;
            r_mpie        <= 1'b0;
            r_meie        <= 1'b0;
            r_mtvec       <= MTVEC_RESET[31:2];
            r_mepc        <= '0;
            r_mcause      <= '0;
            r_mtval       <= '0;
            r_redirect_pc <= '0;
        end else if (w_take_exc || w_take_irq) begin
            r_mepc        <= w_take_exc ? exc_pc_i[31:2] : irq_pc_i[31:2];
            r_mcause      <= w_take_exc ? {27'b0, exc_cause_i} : {1'b1, 26'b0, c_cause_mei};
            r_mtval       <= w_take_exc ? exc_tval_i : 32'h0;
            r_mpie        <= r_mie;
            r_mie         <= 1'b0;
            r_redirect_pc <= {r_mtvec, 2'b00};
        end else if (w_take_mret) begin
            r_mie         <= r_mpie;
            r_mpie        <= 1'b1;
            r_redirect_pc <= {r_mepc, 2'b00};
        end else if (w_csr_we) begin
            case (csr_addr_i)
                c_addr_mstatus: begin
                    r_mie  <= w_wval[c_mstatus_mie];
                    r_mpie <= w_wval[c_mstatus_mpie];
                end
                c_addr_mie:    r_meie   <= w_wval[c_mie_meie];
                c_addr_mtvec:  r_mtvec  <= w_wval[31:2];
                c_addr_mepc:   r_mepc   <= w_wval[31:2];
                c_addr_mcause: r_mcause <= w_wval;
                c_addr_mtval:  r_mtval  <= w_wval;
                default: ;
            endcase
        end
    end

    assign redirect_o    = (r_state == REDIRECT);
    assign redirect_pc_o = r_redirect_pc;
    assign stall_o       = (r_state == SLEEP);

endmodule

`default_nettype wire

// File: tb/tb_rv32_trap_csr_unit.sv
// ============================================================================
// Module      : tb_rv32_trap_csr_unit
// Description : Directed self-checking bench for rv32_trap_csr_unit with a
//               behavioural CSR/trap model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32_trap_csr_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_req_i, mret_i, wfi_i, irq_ext_i, instr_retire_i, exc_valid_i;
    logic [1:0]  csr_op_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i, exc_pc_i, exc_tval_i, irq_pc_i;
    logic [4:0]  exc_cause_i;
    logic [31:0] csr_rdata_o, redirect_pc_o;
    logic        csr_illegal_o, redirect_o, stall_o;

    int checks = 0;
    int errors = 0;

    rv32_trap_csr_unit dut (
        .clk            (clk),
        .rst            (rst),
        .csr_req_i      (csr_req_i),
        .csr_op_i       (csr_op_i),
        .csr_addr_i     (csr_addr_i),
        .csr_wdata_i    (csr_wdata_i),
        .csr_rdata_o    (csr_rdata_o),
        .csr_illegal_o  (csr_illegal_o),
        .exc_valid_i    (exc_valid_i),
        .exc_cause_i    (exc_cause_i),
        .exc_pc_i       (exc_pc_i),
        .exc_tval_i     (exc_tval_i),
        .mret_i         (mret_i),
        .wfi_i          (wfi_i),
        .irq_ext_i      (irq_ext_i),
        .irq_pc_i       (irq_pc_i),
        .instr_retire_i (instr_retire_i),
        .redirect_o     (redirect_o),
        .redirect_pc_o  (redirect_pc_o),
        .stall_o        (stall_o)
    );

    always #5 clk = ~clk;

    // Architectural model: whole CSR words as software would see them.
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mtval, m_redirect_pc;
    logic        m_redirect, m_sleep;
`ifdef RISCV_ZICNTR_EN
    logic [63:0] m_mcycle, m_minstret;
`endif

    task automatic model_reset();
        m_mstatus = 32'h0000_1800;
        m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_redirect_pc = 0; m_redirect = 0; m_sleep = 0;
`ifdef RISCV_ZICNTR_EN
        m_mcycle = 0; m_minstret = 0;
`endif
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a, output bit legal);
        legal = 1'b1;
        case (a)
            12'h300: return m_mstatus;
            12'h301: return 32'h4000_0100;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
`ifdef RISCV_ZICNTR_EN
            12'hB00: return m_mcycle[31:0];
            12'hB80: return m_mcycle[63:32];
            12'hB02: return m_minstret[31:0];
            12'hB82: return m_minstret[63:32];
`endif
            default: begin legal = 1'b0; return 32'h0; end
        endcase
    endfunction

    task automatic enter_trap(input logic [31:0] epc, input logic [31:0] cause, input logic [31:0] tval);
        m_redirect_pc = m_mtvec;
        m_mepc        = epc & ~32'h3;
        m_mcause      = cause;
        m_mtval       = tval;
        m_mstatus[7]  = m_mstatus[3];
        m_mstatus[3]  = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic idle();
        csr_req_i = 0; csr_op_i = 0; csr_addr_i = 0; csr_wdata_i = 0;
        exc_valid_i = 0; exc_cause_i = 0; exc_pc_i = 0; exc_tval_i = 0;
        mret_i = 0; wfi_i = 0; irq_ext_i = 0; irq_pc_i = 0; instr_retire_i = 0;
    endtask

    // One clock: compare DUT with the model, step the model across the edge.
    task automatic tick();
        bit          legal, do_wr;
        logic [31:0] old, wv;
`ifdef RISCV_ZICNTR_EN
        logic [63:0] pc, pi;
`endif
        #2;
        old = m_read(csr_addr_i, legal);
        chk("redirect", 32'(redirect_o), 32'(m_redirect));
        chk("redirect_pc", redirect_pc_o, m_redirect_pc);
        chk("stall", 32'(stall_o), 32'(m_sleep));
        chk("illegal", 32'(csr_illegal_o), 32'(csr_req_i && !legal));
        if (csr_req_i && legal) chk("rdata", csr_rdata_o, old);
        @(posedge clk);
        do_wr = 1'b0;
        wv    = old;
        if (m_redirect) begin
            m_redirect = 1'b0;
        end else if (m_sleep) begin
            if (irq_ext_i && m_mie[11]) begin
                m_sleep = 1'b0;
                if (m_mstatus[3]) begin
                    enter_trap(irq_pc_i, 32'h8000_000B, 32'h0);
                    m_redirect = 1'b1;
                end
            end
        end else if (exc_valid_i) begin
            enter_trap(exc_pc_i, {27'b0, exc_cause_i}, exc_tval_i);
            m_redirect = 1'b1;
        end else if (mret_i) begin
            m_redirect_pc = m_mepc;
            m_mstatus[3]  = m_mstatus[7];
            m_mstatus[7]  = 1'b1;
            m_redirect    = 1'b1;
        end else if (irq_ext_i && m_mie[11] && m_mstatus[3]) begin
            enter_trap(irq_pc_i, 32'h8000_000B, 32'h0);
            m_redirect = 1'b1;
        end else if (wfi_i) begin
            m_sleep = 1'b1;
        end else if (csr_req_i && csr_op_i != 2'b00 && legal) begin
            do_wr = 1'b1;
            case (csr_op_i)
                2'b01:   wv = csr_wdata_i;
                2'b10:   wv = old | csr_wdata_i;
                default: wv = old & ~csr_wdata_i;
            endcase
            case (csr_addr_i)
                12'h300: m_mstatus = 32'h1800 | (wv & 32'h88);
                12'h304: m_mie     = wv & 32'h800;
                12'h305: m_mtvec   = wv & ~32'h3;
                12'h341: m_mepc    = wv & ~32'h3;
                12'h342: m_mcause  = wv;
                12'h343: m_mtval   = wv;
                default: ;
            endcase
        end
`ifdef RISCV_ZICNTR_EN
        pc = m_mcycle;
        pi = m_minstret;
        m_mcycle   = pc + 64'd1;
        m_minstret = pi + 64'(instr_retire_i);
        if (do_wr) begin
            case (csr_addr_i)
                12'hB00: m_mcycle   = {pc[63:32], wv};
                12'hB80: m_mcycle   = {wv, pc[31:0]};
                12'hB02: m_minstret = {pi[63:32], wv};
                12'hB82: m_minstret = {wv, pi[31:0]};
                default: ;
            endcase
        end
`else
        if (do_wr && wv === 32'hx) m_mtval = wv;
`endif
        #1;
        idle();
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
        csr_req_i = 1; csr_op_i = 2'b00; csr_addr_i = a;
        #1;
        chk(name, csr_rdata_o, exp);
        tick();
    endtask

    task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_req_i = 1; csr_op_i = op; csr_addr_i = a; csr_wdata_i = d;
        tick();
    endtask

    initial begin
        idle();
        model_reset();
        #12;
        chk("rst_redirect", 32'(redirect_o), 32'h0);
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_redirect_pc", redirect_pc_o, 32'h0);
        rst = 0;
        tick();

        rd(12'h300, 32'h0000_1800, "rst_mstatus");
        rd(12'h301, 32'h4000_0100, "rst_misa");
        rd(12'h305, 32'h0000_0000, "rst_mtvec");

        wr(2'b01, 12'h305, 32'h0000_0103);
        rd(12'h305, 32'h0000_0100, "mtvec_masked");

        // Exception; the stray exception in the redirect cycle must be ignored.
        exc_valid_i = 1; exc_cause_i = 5'd2; exc_pc_i = 32'h40; exc_tval_i = 32'hDEAD;
        tick();
        exc_valid_i = 1; exc_cause_i = 5'd0; exc_pc_i = 32'h999;
        #1;
        chk("exc_redirect", 32'(redirect_o), 32'h1);
        chk("exc_target", redirect_pc_o, 32'h100);
        tick();
        rd(12'h341, 32'h40, "exc_mepc");
        rd(12'h342, 32'h2, "exc_mcause");
        rd(12'h343, 32'hDEAD, "exc_mtval");
        rd(12'h300, 32'h1800, "exc_mie_clear");

        wr(2'b10, 12'h300, 32'h8);
        wr(2'b10, 12'h304, 32'h800);
        rd(12'h300, 32'h1808, "mstatus_set_mie");
        rd(12'h304, 32'h800, "mie_meie");

        exc_valid_i = 1; exc_cause_i = 5'd11; exc_pc_i = 32'h84;
        tick();
        tick();
        rd(12'h300, 32'h1880, "trap_mpie");
        mret_i = 1;
        tick();
        #1;
        chk("mret_redirect", 32'(redirect_o), 32'h1);
        chk("mret_target", redirect_pc_o, 32'h84);
        tick();
        rd(12'h300, 32'h1888, "mret_mstatus");

        // WFI with interrupts enabled, woken by external interrupt.
        wfi_i = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wfi_stall", 32'(stall_o), 32'h1);
            tick();
        end
        irq_ext_i = 1; irq_pc_i = 32'h200;
        tick();
        #1;
        chk("wake_redirect", 32'(redirect_o), 32'h1);
        chk("wake_target", redirect_pc_o, 32'h100);
        irq_ext_i = 1;
        tick();
        irq_ext_i = 1;
        tick();
        rd(12'h342, 32'h8000_000B, "irq_mcause");
        rd(12'h341, 32'h200, "irq_mepc");
        rd(12'h300, 32'h1880, "irq_mstatus");

        // WFI with MIE clear: wake without trapping.
        wfi_i = 1;
        tick();
        tick();
        irq_ext_i = 1;
        tick();
        #1;
        chk("wake_norun_stall", 32'(stall_o), 32'h0);
        chk("wake_norun_redirect", 32'(redirect_o), 32'h0);
        tick();

        // Exception beats a same-cycle CSR write.
        exc_valid_i = 1; exc_cause_i = 5'd0; exc_pc_i = 32'h10; exc_tval_i = 32'h5;
        csr_req_i = 1; csr_op_i = 2'b01; csr_addr_i = 12'h304; csr_wdata_i = 32'h0;
        tick();
        tick();
        rd(12'h304, 32'h800, "prio_mie_kept");
        rd(12'h342, 32'h0, "prio_mcause");

        // MRET beats WFI and a CSR write.
        mret_i = 1; wfi_i = 1;
        csr_req_i = 1; csr_op_i = 2'b01; csr_addr_i = 12'h343; csr_wdata_i = 32'h77;
        tick();
        tick();
        rd(12'h343, 32'h5, "prio_mtval_kept");

        csr_req_i = 1; csr_op_i = 2'b01; csr_addr_i = 12'h7FF; csr_wdata_i = 32'h1;
        #1;
        chk("illegal_7ff", 32'(csr_illegal_o), 32'h1);
        tick();

        wr(2'b11, 12'h304, 32'h800);
        rd(12'h304, 32'h0, "rc_mie");

        // Interrupt beats WFI in RUN.
        wr(2'b10, 12'h300, 32'h8);
        wr(2'b10, 12'h304, 32'h800);
        irq_ext_i = 1; wfi_i = 1; irq_pc_i = 32'h300;
        tick();
        #1;
        chk("irq_over_wfi", 32'(redirect_o), 32'h1);
        tick();
        rd(12'h341, 32'h300, "irq_over_wfi_mepc");

`ifdef RISCV_ZICNTR_EN
        wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        tick();
        rd(12'hB80, 32'h1, "mcycleh_carry");
        wr(2'b01, 12'hB02, 32'h0);
        for (int i = 0; i < 3; i++) begin
            instr_retire_i = 1;
            tick();
        end
        rd(12'hB02, 32'h3, "minstret_count");
`else
        csr_req_i = 1; csr_op_i = 2'b00; csr_addr_i = 12'hB00;
        #1;
        chk("mcycle_illegal", 32'(csr_illegal_o), 32'h1);
        tick();
`endif

        // Asynchronous reset while sleeping.
        wfi_i = 1;
        tick();
        tick();
        rst = 1;
        #1;
        model_reset();
        chk("async_rst_stall", 32'(stall_o), 32'h0);
        csr_req_i = 1; csr_op_i = 2'b00; csr_addr_i = 12'h305;
        #1;
        chk("async_rst_mtvec", csr_rdata_o, 32'h0);
        idle();
        rst = 0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
